// File: rtl/spi_sram_responder.sv
// SPI mode-0 responder emulating a 23LC-style serial SRAM (READ 0x03, WRITE 0x02) with backdoor load.
// Define SPI_RESP_STATUS_EN to add RDSR (0x05) / WRSR (0x01) and the byte/sequential mode register.
module spi_sram_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy
);
    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic [7:0]  OP_WRITE = 8'h02;
    localparam logic [7:0]  OP_READ  = 8'h03;
`ifdef SPI_RESP_STATUS_EN
    localparam logic [7:0]  OP_WRSR  = 8'h01;
    localparam logic [7:0]  OP_RDSR  = 8'h05;
`endif

    typedef logic [ADDR_W-1:0] addr_t;
    typedef enum logic [2:0] {
        StIdle, StCmd, StAddrHi, StAddrLo, StRead, StWrite, StIgnore
    } state_e;

    logic [7:0] mem [DEPTH];

    logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic       sclk_prev_q, cs_prev_q;
    logic       rise, fall, cs_rise, cs_fall, mosi_s;

    state_e     state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] rx_q, rx_d, rx_next;
    logic [7:0] op_q, op_d;
    logic [7:0] addr_hi_q, addr_hi_d;
    addr_t      addr_q, addr_d, addr_next, addr_load;
    logic [7:0] tx_q, tx_d;
    logic       miso_q, miso_d;
    logic       busy_q, busy_d;
    logic       wr_pend_q, wr_pend_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       init_q;
    addr_t      init_cnt_q;
    logic       load_ok;

    logic       seq_mode, op_is_rdsr, op_is_wrsr;
    logic [7:0] status;

    // Sync flops reset to 0 so a reset taken mid-frame never sees a fresh cs fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            cs_sync_q   <= {cs_sync_q[0], cs};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            sclk_prev_q <= sclk_sync_q[1];
            cs_prev_q   <= cs_sync_q[1];
        end
    end

    assign rise    = sclk_sync_q[1] & ~sclk_prev_q;
    assign fall    = ~sclk_sync_q[1] & sclk_prev_q;
    assign cs_rise = cs_sync_q[1] & ~cs_prev_q;
    assign cs_fall = ~cs_sync_q[1] & cs_prev_q;
    assign mosi_s  = mosi_sync_q[1];

    assign rx_next   = {rx_q[6:0], mosi_s};
    assign addr_load = addr_t'({addr_hi_q, rx_next});
    assign addr_next = seq_mode ? addr_q + addr_t'(1) : addr_q;

`ifdef SPI_RESP_STATUS_EN
    logic [1:0] mode_q, mode_d;

    assign seq_mode   = (mode_q != 2'b00);
    assign status     = {mode_q, 6'b0};
    assign op_is_rdsr = (op_q == OP_RDSR);
    assign op_is_wrsr = (op_q == OP_WRSR);

    always_comb begin
        mode_d = mode_q;
        if (!init_q && !cs_rise && state_q == StWrite && op_is_wrsr && rise && bit_q == 3'd7) begin
            mode_d = rx_next[7:6];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mode_q <= 2'b10;
        else     mode_q <= mode_d;
    end
`else
    assign seq_mode   = 1'b1;
    assign status     = 8'h00;
    assign op_is_rdsr = 1'b0;
    assign op_is_wrsr = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        rx_d      = rx_q;
        op_d      = op_q;
        addr_hi_d = addr_hi_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        busy_d    = busy_q;
        wr_pend_d = 1'b0;
        wr_data_d = wr_data_q;

        // The byte committed this clk advances the address, even if cs has just risen.
        if (wr_pend_q) addr_d = addr_next;

        if (init_q) begin
            state_d = StIdle;
            busy_d  = 1'b0;
        end else if (cs_rise) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            miso_d  = 1'b0;
            bit_d   = '0;
            rx_d    = '0;
        end else if (cs_fall && state_q == StIdle) begin
            state_d = StCmd;
            busy_d  = 1'b1;
            bit_d   = '0;
            rx_d    = '0;
        end else begin
            unique case (state_q)
                StCmd: begin
                    if (rise) begin
                        rx_d  = rx_next;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            op_d = rx_next;
                            case (rx_next)
                                OP_READ, OP_WRITE: state_d = StAddrHi;
`ifdef SPI_RESP_STATUS_EN
                                OP_RDSR: begin
                                    state_d = StRead;
                                    tx_d    = status;
                                end
                                OP_WRSR: state_d = StWrite;
`endif
                                default: state_d = StIgnore;
                            endcase
                        end
                    end
                end
                StAddrHi: begin
                    if (rise) begin
                        rx_d  = rx_next;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            addr_hi_d = rx_next;
                            state_d   = StAddrLo;
                        end
                    end
                end
                StAddrLo: begin
                    if (rise) begin
                        rx_d  = rx_next;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            addr_d = addr_load;
                            if (op_q == OP_READ) begin
                                state_d = StRead;
                                tx_d    = mem[addr_load];
                            end else begin
                                state_d = StWrite;
                            end
                        end
                    end
                end
                StRead: begin
                    if (fall) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                        bit_d  = bit_q + 3'd1;
                        // Last bit of the byte is out: prefetch the next one behind it.
                        if (bit_q == 3'd7) begin
                            if (op_is_rdsr) begin
                                tx_d = status;
                            end else begin
                                addr_d = addr_next;
                                tx_d   = mem[addr_next];
                            end
                        end
                    end
                end
                StWrite: begin
                    if (rise) begin
                        rx_d  = rx_next;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            wr_pend_d = ~op_is_wrsr;
                            wr_data_d = rx_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_q     <= '0;
            rx_q      <= '0;
            op_q      <= '0;
            addr_hi_q <= '0;
            addr_q    <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            busy_q    <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            rx_q      <= rx_d;
            op_q      <= op_d;
            addr_hi_q <= addr_hi_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            busy_q    <= busy_d;
            wr_pend_q <= wr_pend_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q     <= (INIT_ZERO != 0);
            init_cnt_q <= '0;
        end else if (init_q) begin
            init_cnt_q <= init_cnt_q + addr_t'(1);
            if (init_cnt_q == '1) init_q <= 1'b0;
        end
    end

    // Backdoor is allowed while synced cs is high, including the clk its fall is first seen.
    assign load_ok = load_en & (cs_sync_q[1] | cs_prev_q) & ~init_q;

    always_ff @(posedge clk) begin
        if (init_q)         mem[init_cnt_q] <= 8'h00;
        else if (wr_pend_q) mem[addr_q]     <= wr_data_q;
        else if (load_ok)   mem[load_addr]  <= load_data;
    end

    assign miso    = miso_q;
    assign miso_oe = (state_q == StRead) & ~cs_sync_q[1];
    assign busy    = busy_q | init_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Self-checking bench for spi_sram_responder: SPI mode-0 initiator tasks, reference memory
// model and a byte scoreboard for read data.
module tb_spi_sram_responder;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              sclk, cs, mosi, miso, miso_oe, load_en, busy;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] model [DEPTH];
    logic [7:0] exp_q [$];
    logic       seq_mode = 1'b1;

    spi_sram_responder #(
        .ADDR_W   (ADDR_W),
        .INIT_ZERO(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // SCLK half period is 4 clk; miso is sampled just before each rise.
    task automatic spi_bits(input logic [7:0] d, input int nbits, output logic [7:0] r,
                            output logic oe_any, output logic oe_all);
        r      = '0;
        oe_any = 1'b0;
        oe_all = 1'b1;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = d[i];
            repeat (4) @(negedge clk);
            r[i]   = miso;
            oe_any = oe_any | miso_oe;
            oe_all = oe_all & miso_oe;
            sclk   = 1'b1;
            repeat (4) @(negedge clk);
            sclk   = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] d, output logic [7:0] r,
                            output logic oe_any, output logic oe_all);
        spi_bits(d, 8, r, oe_any, oe_all);
    endtask

    task automatic frame_begin();
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic backdoor(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        if (cs === 1'b1) model[a] = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k = 0;
        while (busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, busy, 1'b0);
    endtask

    task automatic write_frame(input logic [15:0] addr, input int n, input logic [31:0] data);
        logic [7:0]        r, d;
        logic              a, b;
        logic [ADDR_W-1:0] ma;
        ma = addr[ADDR_W-1:0];
        frame_begin();
        spi_byte(8'h02, r, a, b);
        spi_byte(addr[15:8], r, a, b);
        spi_byte(addr[7:0], r, a, b);
        for (int i = 0; i < n; i++) begin
            d = data[31 - 8 * i -: 8];
            spi_byte(d, r, a, b);
            model[ma] = d;
            if (seq_mode) ma = ma + 1'b1;
        end
        frame_end();
    endtask

    task automatic read_frame(input logic [15:0] addr, input int n, input string tag);
        logic [7:0]        r, e;
        logic              a, b, hdr_oe;
        logic [ADDR_W-1:0] ma;
        ma = addr[ADDR_W-1:0];
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model[ma]);
            if (seq_mode) ma = ma + 1'b1;
        end
        frame_begin();
        spi_byte(8'h03, r, a, b);
        hdr_oe = a;
        spi_byte(addr[15:8], r, a, b);
        hdr_oe = hdr_oe | a;
        spi_byte(addr[7:0], r, a, b);
        hdr_oe = hdr_oe | a;
        check_eq({tag, "_hdr_oe"}, hdr_oe, 1'b0);
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, r, a, b);
            e = exp_q.pop_front();
            check_eq({tag, "_data"}, r, e);
            check_eq({tag, "_oe"}, b, 1'b1);
        end
        frame_end();
        check_eq({tag, "_oe_idle"}, miso_oe, 1'b0);
    endtask

    initial begin
        logic [7:0] r;
        logic       a, b, any;

        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_busy_sweep", busy, 1'b1);
        check_eq("rst_miso", miso, 1'b0);
        check_eq("rst_miso_oe", miso_oe, 1'b0);
        rst = 1'b0;
        wait_idle("init_sweep_done", 3000);
        repeat (4) @(negedge clk);

        // Backdoor preload then sequential read.
        backdoor(10'h010, 8'hA5);
        backdoor(10'h011, 8'h3C);
        @(negedge clk);
        read_frame(16'h0010, 2, "rd_preload");

        write_frame(16'h0020, 3, 32'h1122_3300);
        read_frame(16'h0020, 3, "rd_write");

        // Address wrap and ignored upper address bits.
        write_frame(16'h03FF, 2, 32'hAABB_0000);
        read_frame(16'h03FF, 2, "rd_wrap");
        read_frame(16'hFC10, 1, "rd_upper_ign");

        // Partial byte then cs high: discarded, responder idles quickly.
        write_frame(16'h0040, 1, 32'hF000_0000);
        frame_begin();
        spi_byte(8'h02, r, a, b);
        spi_byte(8'h00, r, a, b);
        spi_byte(8'h40, r, a, b);
        spi_bits(8'h0F, 5, r, a, b);
        cs = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_oe", miso_oe, 1'b0);
        check_eq("abort_miso", miso, 1'b0);
        repeat (6) @(negedge clk);
        read_frame(16'h0040, 1, "rd_abort");

        // Unknown opcode, with a backdoor attempt while cs is low.
        frame_begin();
        spi_byte(8'h9F, r, a, b);
        any = a;
        spi_byte(8'h00, r, a, b);
        any = any | a;
        backdoor(10'h050, 8'h77);
        spi_byte(8'h10, r, a, b);
        any = any | a;
        check_eq("ign_busy", busy, 1'b1);
        frame_end();
        check_eq("ign_oe", any, 1'b0);
        read_frame(16'h0050, 1, "rd_bd_cs_low");
        read_frame(16'h0010, 2, "rd_after_ign");

`ifdef SPI_RESP_STATUS_EN
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h80);
        frame_begin();
        spi_byte(8'h05, r, a, b);
        for (int i = 0; i < 2; i++) begin
            spi_byte(8'h00, r, a, b);
            check_eq("rdsr_data", r, exp_q.pop_front());
            check_eq("rdsr_oe", b, 1'b1);
        end
        frame_end();
        frame_begin();
        spi_byte(8'h01, r, a, b);
        spi_byte(8'h00, r, a, b);
        frame_end();
        seq_mode = 1'b0;
        read_frame(16'h0010, 2, "rd_byte_mode");
        frame_begin();
        spi_byte(8'h01, r, a, b);
        spi_byte(8'hFF, r, a, b);
        frame_end();
        exp_q.push_back(8'hC0);
        frame_begin();
        spi_byte(8'h05, r, a, b);
        spi_byte(8'h00, r, a, b);
        check_eq("rdsr_masked", r, exp_q.pop_front());
        frame_end();
        seq_mode = 1'b1;
        read_frame(16'h0010, 2, "rd_seq_11");
`else
        frame_begin();
        spi_byte(8'h05, r, a, b);
        any = a;
        spi_byte(8'h00, r, a, b);
        any = any | a;
        spi_byte(8'h00, r, a, b);
        any = any | a;
        frame_end();
        check_eq("rdsr_absent_oe", any, 1'b0);
`endif

        // Reset in the middle of a write frame: rest of the frame is ignored, array cleared.
        frame_begin();
        spi_byte(8'h02, r, a, b);
        spi_byte(8'h00, r, a, b);
        spi_byte(8'h60, r, a, b);
        spi_bits(8'hE0, 4, r, a, b);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
        seq_mode = 1'b1;
        check_eq("midrst_busy", busy, 1'b1);
        spi_byte(8'hEE, r, a, b);
        spi_byte(8'hEE, r, a, b);
        check_eq("midrst_oe", miso_oe, 1'b0);
        frame_end();
        wait_idle("midrst_sweep_done", 3000);
        repeat (4) @(negedge clk);
        read_frame(16'h0060, 2, "rd_midrst");
        read_frame(16'h0010, 1, "rd_cleared");

        check_eq("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
